// File: rtl/connect4_pkg.sv
// Shared Connect 4 definitions: command encodings, PS/2 scan-code constants,
// decoder state type and scan-code lookup helpers.
package connect4_pkg;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LEFT  = 2'd1;
    localparam logic [1:0] CMD_RIGHT = 2'd2;
    localparam logic [1:0] CMD_PLACE = 2'd3;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    function automatic logic [1:0] map_normal(input logic [7:0] code);
        case (code)
            SC_A:     return CMD_LEFT;
            SC_D:     return CMD_RIGHT;
            SC_SPACE: return CMD_PLACE;
            default:  return CMD_NONE;
        endcase
    endfunction

    function automatic logic [1:0] map_extended(input logic [7:0] code);
        case (code)
            SC_LEFT:  return CMD_LEFT;
            SC_RIGHT: return CMD_RIGHT;
            SC_DOWN:  return CMD_PLACE;
            default:  return CMD_NONE;
        endcase
    endfunction

    // One-hot key_held position for a command; CMD_NONE maps to no bit.
    function automatic logic [2:0] cmd_onehot(input logic [1:0] c);
        case (c)
            CMD_LEFT:  return 3'b001;
            CMD_RIGHT: return 3'b010;
            CMD_PLACE: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_move_decoder_fifo.sv
// move_cmd_fifo: synchronous show-ahead FIFO; a push while full is dropped
// (and pulses o_overflow) unless a pop frees the slot in the same cycle.
module move_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_pop;
    logic             w_push_ok;

    assign o_valid    = (r_count != {(AW+1){1'b0}});
    assign o_full     = (r_count == FULL_CNT);
    assign w_pop      = i_pop && o_valid;
    assign w_push_ok  = i_push && (!o_full || w_pop);
    assign o_data     = o_valid ? r_mem[r_rd_ptr] : {WIDTH{1'b0}};
    assign o_overflow = r_overflow;

    // Storage array; contents need no reset because r_count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy and the dropped-push pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {(AW+1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_overflow <= i_push && !w_push_ok;
        end
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 scan-code to game-command decoder with typematic suppression and a
// command FIFO. Define PS2_ARROW_KEYS_EN to enable the arrow-key aliases.
import connect4_pkg::*;

module ps2_move_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    input  logic       cmd_ready,
    output logic [2:0] key_held,
    output logic       overflow
);

    dec_state_e r_state;
    dec_state_e w_state_nxt;
    logic [5:0] r_pressed;
    logic [2:0] r_key_held;
    logic [1:0] w_norm_cmd;
    logic [1:0] w_ext_cmd;
    logic [5:0] w_norm_mask;
    logic [5:0] w_ext_mask;
    logic [5:0] w_press_mask;
    logic [5:0] w_release_mask;
    logic [5:0] w_pressed_nxt;
    logic       w_push;
    logic [1:0] w_push_cmd;
    logic       w_fifo_full;

    assign w_norm_cmd = map_normal(received_data);
`ifdef PS2_ARROW_KEYS_EN
    assign w_ext_cmd = map_extended(received_data);
    localparam logic [5:0] PRESS_MASK = 6'b111111;
`else
    // E0 is still tracked as a prefix, but no extended code is ever mapped.
    assign w_ext_cmd = CMD_NONE;
    localparam logic [5:0] PRESS_MASK = 6'b000111;
`endif

    // Bits [2:0] hold the normal keys, [5:3] their extended aliases.
    assign w_norm_mask = {3'b000, cmd_onehot(w_norm_cmd)};
    assign w_ext_mask  = {cmd_onehot(w_ext_cmd), 3'b000};

    // Prefix FSM: selects which key, if any, is pressed or released by this byte.
    always_comb begin
        w_state_nxt    = r_state;
        w_press_mask   = 6'b000000;
        w_release_mask = 6'b000000;
        if (received_data_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (received_data == SC_BREAK) begin
                        w_state_nxt = ST_BRK;
                    end else if (received_data == SC_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else begin
                        w_press_mask = w_norm_mask;
                    end
                end
                ST_EXT: begin
                    if (received_data == SC_BREAK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_press_mask = w_ext_mask;
                        w_state_nxt  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_release_mask = w_norm_mask;
                    w_state_nxt    = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_release_mask = w_ext_mask;
                    w_state_nxt    = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // A press only produces a command on the clear-to-set edge of its bit.
    assign w_push        = (w_press_mask != 6'b000000) && ((r_pressed & w_press_mask) == 6'b000000);
    assign w_push_cmd    = (r_state == ST_EXT) ? w_ext_cmd : w_norm_cmd;
    assign w_pressed_nxt = ((r_pressed | w_press_mask) & ~w_release_mask) & PRESS_MASK;

    // Decoder state, pressed bits and the registered key_held level.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_pressed  <= 6'b000000;
            r_key_held <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_pressed  <= w_pressed_nxt;
            r_key_held <= w_pressed_nxt[2:0] | w_pressed_nxt[5:3];
        end
    end

    assign key_held = r_key_held;

    move_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .i_clk      (Clock),
        .i_rst      (Reset),
        .i_push     (w_push),
        .i_data     (w_push_cmd),
        .i_pop      (cmd_ready),
        .o_valid    (cmd_valid),
        .o_data     (cmd),
        .o_full     (w_fifo_full),
        .o_overflow (overflow)
    );

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Self-checking bench for ps2_move_decoder: directed test-plan steps followed
// by random byte traffic, every cycle compared against a keyboard-level model.
module tb_ps2_move_decoder;

    localparam int DEPTH = 4;
`ifdef PS2_ARROW_KEYS_EN
    localparam bit ARROWS = 1'b1;
`else
    localparam bit ARROWS = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [2:0] key_held;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Model: prefix flags, pressed keys per (table, command), command queue.
    bit        m_brk;
    bit        m_ext;
    bit [5:0]  m_held;
    int        m_q[$];
    bit        m_ovf;

    ps2_move_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .cmd_valid        (cmd_valid),
        .cmd              (cmd),
        .cmd_ready        (cmd_ready),
        .key_held         (key_held),
        .overflow         (overflow)
    );

    always #5 Clock = ~Clock;

    function automatic int lookup(input bit ext, input logic [7:0] b);
        if (!ext) begin
            if (b == 8'h1C) return 1;
            if (b == 8'h23) return 2;
            if (b == 8'h29) return 3;
            return 0;
        end
        if (!ARROWS) return 0;
        if (b == 8'h6B) return 1;
        if (b == 8'h74) return 2;
        if (b == 8'h72) return 3;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input bit e, input logic [7:0] b, input bit r);
        bit pop;
        int c;
        int idx;
        bit push;
        int pc;
        pop   = (m_q.size() > 0) && r;
        push  = 1'b0;
        pc    = 0;
        m_ovf = 1'b0;
        if (e) begin
            if (m_brk) begin
                c = lookup(m_ext, b);
                if (c != 0) begin
                    idx = (m_ext ? 3 : 0) + c - 1;
                    m_held[idx] = 1'b0;
                end
                m_brk = 1'b0;
                m_ext = 1'b0;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (m_ext || b != 8'hE0) begin
                c = lookup(m_ext, b);
                if (c != 0) begin
                    idx = (m_ext ? 3 : 0) + c - 1;
                    if (!m_held[idx]) begin
                        m_held[idx] = 1'b1;
                        push = 1'b1;
                        pc   = c;
                    end
                end
                m_ext = 1'b0;
            end else begin
                m_ext = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(pc);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e_cmd;
        logic [2:0] e_held;
        e_cmd  = (m_q.size() > 0) ? 8'(m_q[0]) : 8'h00;
        e_held = m_held[2:0] | m_held[5:3];
        chk({tag, ".valid"}, {7'd0, cmd_valid}, {7'd0, m_q.size() > 0});
        chk({tag, ".cmd"}, {6'd0, cmd}, e_cmd);
        chk({tag, ".held"}, {5'd0, key_held}, {5'd0, e_held});
        chk({tag, ".ovf"}, {7'd0, overflow}, {7'd0, m_ovf});
    endtask

    task automatic step(input string tag, input bit e, input logic [7:0] b, input bit r);
        received_data_en = e;
        received_data    = b;
        cmd_ready        = r;
        model_byte(e, b, r);
        @(posedge Clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        Reset            = 1'b1;
        received_data_en = 1'b0;
        cmd_ready        = 1'b0;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_held = 6'b0;
        m_ovf  = 1'b0;
        m_q.delete();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check_all(tag);
    endtask

    logic [7:0] pool [12] = '{8'h1C, 8'h23, 8'h29, 8'h6B, 8'h74, 8'h72,
                              8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h15};

    initial begin
        received_data    = 8'h00;
        received_data_en = 1'b0;
        cmd_ready        = 1'b0;
        Reset            = 1'b1;
        #1;
        do_reset("rst");
        chk("rst.valid0", {7'd0, cmd_valid}, 8'h00);

        // A press/release, consumer always ready
        step("a_press", 1'b1, 8'h1C, 1'b1);
        chk("a_left", {6'd0, cmd}, 8'h01);
        chk("a_held", {5'd0, key_held}, 8'h01);
        step("a_brk", 1'b1, 8'hF0, 1'b1);
        step("a_rel", 1'b1, 8'h1C, 1'b1);
        chk("a_held_rel", {5'd0, key_held}, 8'h00);

        // Typematic D
        for (int i = 0; i < 5; i++) step("d_rep", 1'b1, 8'h23, 1'b0);
        chk("d_held", {5'd0, key_held}, 8'h02);
        step("d_brk", 1'b1, 8'hF0, 1'b1);
        step("d_rel", 1'b1, 8'h23, 1'b1);

        // Down arrow
        step("dn_e0", 1'b1, 8'hE0, 1'b1);
        step("dn_mk", 1'b1, 8'h72, 1'b0);
        chk("dn_held", {5'd0, key_held}, ARROWS ? 8'h04 : 8'h00);
        step("dn_e0b", 1'b1, 8'hE0, 1'b1);
        step("dn_f0", 1'b1, 8'hF0, 1'b1);
        step("dn_rel", 1'b1, 8'h72, 1'b1);

        // Overflow: five presses into a depth-4 FIFO with no consumer
        for (int i = 0; i < 5; i++) begin
            step("ov_mk", 1'b1, pool[i % 3], 1'b0);
            if (i == 4) chk("ov_pulse", {7'd0, overflow}, 8'h01);
            step("ov_f0", 1'b1, 8'hF0, 1'b0);
            step("ov_rel", 1'b1, pool[i % 3], 1'b0);
        end
        // Full FIFO, pop and push on the same cycle
        step("fp_mk", 1'b1, 8'h29, 1'b1);
        chk("fp_noovf", {7'd0, overflow}, 8'h00);
        step("fp_f0", 1'b1, 8'hF0, 1'b0);
        step("fp_rel", 1'b1, 8'h29, 1'b0);
        for (int i = 0; i < 5; i++) step("drain", 1'b0, 8'h00, 1'b1);
        chk("drain_empty", {7'd0, cmd_valid}, 8'h00);

        // Reset mid-prefix, then 6B in IDLE is unmapped
        step("rp_e0", 1'b1, 8'hE0, 1'b1);
        do_reset("rp_rst");
        step("rp_6b", 1'b1, 8'h6B, 1'b0);
        chk("rp_none", {7'd0, cmd_valid}, 8'h00);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd", ($urandom_range(0, 9) < 7),
                     pool[$urandom_range(0, 11)], ($urandom_range(0, 9) < 4));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
